// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 nibble matrix-multiply host driver and its accelerator bench.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_PULSE = 3'd1,
        DRIVE_A   = 3'd2,
        DRIVE_B   = 3'd3,
        WAIT_OUT  = 3'd4,
        CAP2      = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam int A_HOLD_DEF  = 3;
    localparam int B_HOLD_DEF  = 3;
    localparam int TIMEOUT_DEF = 16;

    // A matrix {X00,X01,X10,X11} whose top or bottom row is entirely zero is unusable.
    function automatic logic has_zero_row(input logic [15:0] m);
        return (m[15:8] == 8'h00) || (m[7:0] == 8'h00);
    endfunction

    // One output beat carries two 8-bit results split by nibble across uio_out and uo.
    function automatic logic [15:0] beat_unpack(input logic [7:0] uio_out, input logic [7:0] uo);
        return {uio_out[7:4], uo[7:4], uio_out[3:0], uo[3:0]};
    endfunction

    // Inverse of beat_unpack: returns {uio_out, uo} for results c0 (left) and c1 (right).
    function automatic logic [15:0] beat_pack(input logic [7:0] c0, input logic [7:0] c1);
        return {c0[7:4], c1[7:4], c0[3:0], c1[3:0]};
    endfunction

endpackage

// File: rtl/matmul_host_driver_if.sv
// Job/result handshake and accelerator pin bundle for the matmul host driver.
interface matmul_host_driver_if;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_a;
    logic [15:0] job_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_c;
    logic        res_err;
    logic        acc_rst_n;
    logic [7:0]  acc_ui;
    logic [7:0]  acc_uio;
    logic [7:0]  acc_uo;
    logic [7:0]  acc_uio_out;
    logic [7:0]  acc_uio_oe;

    modport master (
        input  job_valid, job_a, job_b, res_ready, acc_uo, acc_uio_out, acc_uio_oe,
        output job_ready, res_valid, res_c, res_err, acc_rst_n, acc_ui, acc_uio
    );

    modport slave (
        output job_valid, job_a, job_b, res_ready, acc_uo, acc_uio_out, acc_uio_oe,
        input  job_ready, res_valid, res_c, res_err, acc_rst_n, acc_ui, acc_uio
    );
endinterface

// File: rtl/matmul_host_driver.sv
// Sequences one 2x2 matrix job through the accelerator: reset pulse, drive A, drive B,
// wait for the two result beats, then hold the result until the host consumes it.
module matmul_host_driver
    import matmul_pkg::*;
#(
    parameter int A_HOLD  = A_HOLD_DEF,
    parameter int B_HOLD  = B_HOLD_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_host_driver_if.master  bus
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic        err_q, err_d;
    logic        rej_q, rej_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            c_q     <= 32'h0000_0000;
            err_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;
        rej_d   = rej_q;

        unique case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    a_d   = bus.job_a;
                    b_d   = bus.job_b;
                    c_d   = 32'h0000_0000;
                    cnt_d = 8'd0;
                    if (has_zero_row(bus.job_a) || has_zero_row(bus.job_b)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rej_d   = 1'b1;
                    end else begin
                        state_d = RST_PULSE;
                        err_d   = 1'b0;
                        rej_d   = 1'b0;
                    end
                end
            end
            RST_PULSE: begin
                state_d = DRIVE_A;
                cnt_d   = 8'd0;
            end
            DRIVE_A: begin
                if (cnt_q == 8'(A_HOLD - 1)) begin
                    state_d = DRIVE_B;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DRIVE_B: begin
                if (cnt_q == 8'(B_HOLD - 1)) begin
                    state_d = WAIT_OUT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_OUT: begin
                // A beat in the final allowed cycle still wins over the timeout.
                if (bus.acc_uio_oe == 8'hFF) begin
                    c_d[31:16] = beat_unpack(bus.acc_uio_out, bus.acc_uo);
                    state_d    = CAP2;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    c_d     = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CAP2: begin
                c_d[15:0] = beat_unpack(bus.acc_uio_out, bus.acc_uo);
                err_d     = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.job_ready = (state_q == IDLE);
        bus.res_valid = (state_q == DONE);
        bus.res_c     = c_q;
        bus.res_err   = err_q;
        // A rejected job never releases the accelerator from reset.
        bus.acc_rst_n = !((state_q == IDLE) || (state_q == RST_PULSE) ||
                          ((state_q == DONE) && rej_q));
        bus.acc_ui    = 8'h00;
        bus.acc_uio   = 8'h00;
        if ((state_q == RST_PULSE) || (state_q == DRIVE_A)) begin
            bus.acc_ui  = a_q[15:8];
            bus.acc_uio = a_q[7:0];
        end else if ((state_q == DRIVE_B) || (state_q == WAIT_OUT)) begin
            bus.acc_ui  = b_q[15:8];
            bus.acc_uio = b_q[7:0];
        end
    end

endmodule

// File: tb/tb_matmul_host_driver.sv
// Bench for matmul_host_driver: an accelerator model that reads A/B off the bus, plus
// directed and randomized jobs checked against a plain-arithmetic matrix reference.
module tb_matmul_host_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_host_driver_if bus_if ();

    matmul_host_driver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // 2x2 product of nibble matrices, each entry modulo 256, packed {C00,C01,C10,C11}.
    function automatic logic [31:0] ref_mm(input logic [15:0] a, input logic [15:0] b);
        int am [2][2];
        int bm [2][2];
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                am[i][j] = (int'(a) >> (12 - 4 * (2 * i + j))) & 15;
                bm[i][j] = (int'(b) >> (12 - 4 * (2 * i + j))) & 15;
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s;
                s = (am[i][0] * bm[0][j] + am[i][1] * bm[1][j]) % 256;
                r = r | (32'(s) << (24 - 8 * (2 * i + j)));
            end
        return r;
    endfunction

    function automatic logic zero_row(input logic [15:0] m);
        return (m[15:8] == 8'h00) || (m[7:0] == 8'h00);
    endfunction

    // Accelerator model: counts cycles out of reset, samples A and B from the bus at the
    // end of their drive windows, and emits two beats starting at cycle beat_k.
    int          acc_k   = 0;
    int          beat_k  = 10;
    logic [15:0] acc_a   = 16'h0;
    logic [15:0] acc_b   = 16'h0;
    logic [7:0]  idle_oe = 8'h00;
    logic [7:0]  junk_uo = 8'h00;
    logic [7:0]  junk_uio = 8'h00;
    logic [31:0] acc_c;

    always @(posedge clk) begin
        if (bus_if.acc_rst_n !== 1'b1) begin
            acc_k <= 0;
        end else begin
            acc_k <= acc_k + 1;
            if (acc_k == 2) acc_a <= {bus_if.acc_ui, bus_if.acc_uio};
            if (acc_k == 5) acc_b <= {bus_if.acc_ui, bus_if.acc_uio};
        end
    end

    always_comb begin
        acc_c              = ref_mm(acc_a, acc_b);
        bus_if.acc_uo      = junk_uo;
        bus_if.acc_uio_out = junk_uio;
        bus_if.acc_uio_oe  = idle_oe;
        if (bus_if.acc_rst_n === 1'b1 && acc_k == beat_k) begin
            bus_if.acc_uio_oe  = 8'hFF;
            bus_if.acc_uio_out = {acc_c[31:28], acc_c[23:20]};
            bus_if.acc_uo      = {acc_c[27:24], acc_c[19:16]};
        end else if (bus_if.acc_rst_n === 1'b1 && acc_k == beat_k + 1) begin
            bus_if.acc_uio_out = {acc_c[15:12], acc_c[7:4]};
            bus_if.acc_uo      = {acc_c[11:8], acc_c[3:0]};
        end
    end

    logic [7:0] rand_oe;
    always_comb begin
        rand_oe = 8'($urandom_range(0, 254));
    end

    // Offer one job, measure cycles to res_valid, check result, then apply backpressure.
    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input int bk,
                           input logic [7:0] oe_idle, input int hold);
        logic        rej;
        logic        exp_err;
        logic [31:0] exp_c;
        int          exp_lat;
        int          lat;
        int          waits;
        logic        saw_rstn;
        logic [31:0] c_seen;
        logic        e_seen;

        rej     = zero_row(a) || zero_row(b);
        exp_err = rej || (bk > 21);
        exp_c   = exp_err ? 32'h0 : ref_mm(a, b);
        exp_lat = rej ? 1 : ((bk > 21) ? 24 : bk + 4);

        @(negedge clk);
        waits = 0;
        while (bus_if.job_ready !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check("ready_before_job", 32'(bus_if.job_ready), 32'd1);
        beat_k           = bk;
        idle_oe          = oe_idle;
        junk_uo          = 8'($urandom);
        junk_uio         = 8'($urandom);
        bus_if.job_valid = 1'b1;
        bus_if.job_a     = a;
        bus_if.job_b     = b;
        @(posedge clk);
        #1;
        bus_if.job_valid = 1'b0;
        bus_if.job_a     = 16'($urandom);
        bus_if.job_b     = 16'($urandom);

        saw_rstn = 1'b0;
        lat      = 1;
        while (bus_if.res_valid !== 1'b1 && lat < 60) begin
            if (bus_if.acc_rst_n === 1'b1) saw_rstn = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("res_err", 32'(bus_if.res_err), 32'(exp_err));
        check("res_c", bus_if.res_c, exp_c);

        c_seen = bus_if.res_c;
        e_seen = bus_if.res_err;
        bus_if.res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (bus_if.acc_rst_n === 1'b1) saw_rstn = 1'b1;
            @(posedge clk);
            #1;
            check("hold_c", bus_if.res_c, c_seen);
            check("hold_err", 32'(bus_if.res_err), 32'(e_seen));
            check("hold_valid", 32'(bus_if.res_valid), 32'd1);
            check("hold_ready", 32'(bus_if.job_ready), 32'd0);
        end
        if (bus_if.acc_rst_n === 1'b1) saw_rstn = 1'b1;
        if (rej) check("rej_rstn_never", 32'(saw_rstn), 32'd0);

        bus_if.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.res_ready = 1'b0;
        check("idle_after_ready", 32'(bus_if.job_ready), 32'd1);
        check("valid_drop", 32'(bus_if.res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        bus_if.job_valid = 1'b0;
        bus_if.job_a     = 16'h0;
        bus_if.job_b     = 16'h0;
        bus_if.res_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_job_ready", 32'(bus_if.job_ready), 32'd1);
        check("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        check("rst_res_err", 32'(bus_if.res_err), 32'd0);
        check("rst_res_c", bus_if.res_c, 32'h0);
        check("rst_acc_ui", 32'(bus_if.acc_ui), 32'd0);
        check("rst_acc_uio", 32'(bus_if.acc_uio), 32'd0);
        check("rst_acc_rst_n", 32'(bus_if.acc_rst_n), 32'd0);

        run_job(16'h1234, 16'h5678, 10, 8'h00, 0);
        check("basic_c", bus_if.res_c, 32'h13162B32);
        run_job(16'hFFFF, 16'hFFFF, 10, 8'hFE, 0);
        check("overflow_c", bus_if.res_c, 32'hC2C2C2C2);
        run_job(16'h0034, 16'h5678, 10, 8'h00, 2);
        run_job(16'h1200, 16'h5678, 10, 8'h00, 0);
        run_job(16'h1234, 16'h5600, 10, 8'h00, 0);
        run_job(16'h1234, 16'h5678, 255, 8'h7F, 0);
        run_job(16'h2143, 16'h8765, 10, 8'h0F, 5);
        run_job(16'h1111, 16'h2222, 6, 8'h00, 0);
        run_job(16'h9A3C, 16'h7E51, 21, 8'hEF, 0);

        // Abort a job while it waits for output.
        beat_k           = 10;
        idle_oe          = 8'h00;
        @(negedge clk);
        bus_if.job_valid = 1'b1;
        bus_if.job_a     = 16'h4321;
        bus_if.job_b     = 16'h1357;
        @(posedge clk);
        #1;
        bus_if.job_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_job_ready", 32'(bus_if.job_ready), 32'd1);
        check("abort_acc_rst_n", 32'(bus_if.acc_rst_n), 32'd0);
        check("abort_acc_ui", 32'(bus_if.acc_ui), 32'd0);
        check("abort_acc_uio", 32'(bus_if.acc_uio), 32'd0);
        check("abort_res_c", bus_if.res_c, 32'h0);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.res_valid === 1'b1) seen_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        run_job(16'h4321, 16'h1357, 10, 8'h00, 1);

        for (int n = 0; n < 24; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            int          rbk;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 5) == 0) ra[7:0] = 8'h00;
            if ($urandom_range(0, 5) == 0) rb[15:8] = 8'h00;
            rbk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(22, 40))
                                              : int'($urandom_range(6, 21));
            run_job(ra, rb, rbk, rand_oe, int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
